// File: rtl/router_pkg.sv
// Shared router definitions: port numbering, flit layout and the XY
// dimension-order route function.
package router_pkg;

  localparam int M       = 5;
  localparam int COORD_W = 2;
  localparam int DATA_W  = 32;

  localparam int PORT_LOCAL = 0;
  localparam int PORT_NORTH = 1;
  localparam int PORT_EAST  = 2;
  localparam int PORT_SOUTH = 3;
  localparam int PORT_WEST  = 4;

  // Field order mirrors the wire layout: dest_y in the LSBs, payload on top.
  typedef struct packed {
    logic [DATA_W-2*COORD_W-1:0] payload;
    logic [COORD_W-1:0]          dest_x;
    logic [COORD_W-1:0]          dest_y;
  } flit_t;

  // X is resolved first, then Y. A flit already at its destination goes Local.
  function automatic logic [M-1:0] xy_route(
    input logic [COORD_W-1:0] dest_x,
    input logic [COORD_W-1:0] dest_y,
    input logic [COORD_W-1:0] x_loc,
    input logic [COORD_W-1:0] y_loc
  );
    logic [M-1:0] r;
    r = '0;
    if (dest_x > x_loc)      r[PORT_EAST]  = 1'b1;
    else if (dest_x < x_loc) r[PORT_WEST]  = 1'b1;
    else if (dest_y > y_loc) r[PORT_NORTH] = 1'b1;
    else if (dest_y < y_loc) r[PORT_SOUTH] = 1'b1;
    else                     r[PORT_LOCAL] = 1'b1;
    return r;
  endfunction

endpackage

// File: rtl/xy_route_unit.sv
// Combinational XY dimension-order route: one-hot output port for a destination.
module xy_route_unit
  import router_pkg::*;
#(
  parameter int COORD_W = 2,
  parameter int M       = 5
) (
  input  logic [COORD_W-1:0] dest_x,
  input  logic [COORD_W-1:0] dest_y,
  input  logic [COORD_W-1:0] x_loc,
  input  logic [COORD_W-1:0] y_loc,
  output logic [M-1:0]       route
);

  // Unsigned compares; X must be fully corrected before Y is considered.
  always_comb begin
    route = '0;
    if (dest_x > x_loc)      route[PORT_EAST]  = 1'b1;
    else if (dest_x < x_loc) route[PORT_WEST]  = 1'b1;
    else if (dest_y > y_loc) route[PORT_NORTH] = 1'b1;
    else if (dest_y < y_loc) route[PORT_SOUTH] = 1'b1;
    else                     route[PORT_LOCAL] = 1'b1;
  end

endmodule

// File: rtl/input_unit.sv
// Router input port: flit FIFO with route computed at enqueue, head request
// presented to the switch arbiter and popped on grant.
module input_unit
  import router_pkg::*;
#(
  parameter int DEPTH   = 4,
  parameter int DATA_W  = 32,
  parameter int COORD_W = 2,
  parameter int M       = 5,
  parameter int X_LOC   = 0,
  parameter int Y_LOC   = 0
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     ce,
  input  logic [DATA_W-1:0]        i_data,
  input  logic                     i_valid,
  output logic                     o_en,
  output logic [M-1:0]             o_output_req,
  input  logic                     i_input_grant,
  output logic [DATA_W-1:0]        o_data,
  output logic [$clog2(DEPTH):0]   o_count,
  output logic                     o_overflow,
  output logic                     o_underflow
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [DATA_W-1:0] data_mem  [DEPTH];
  logic [M-1:0]      route_mem [DEPTH];
  logic [AW-1:0]     rd_ptr, wr_ptr;
  logic [CW-1:0]     count;
  logic              full, empty, wr, rd;
  logic [M-1:0]      wr_route;

  assign full  = (count == CW'(DEPTH));
  assign empty = (count == '0);
  // Full blocks writes and empty blocks pops, so count stays in [0, DEPTH].
  assign wr    = ce & i_valid & ~full;
  assign rd    = ce & i_input_grant & ~empty;

  xy_route_unit #(.COORD_W(COORD_W), .M(M)) u_route (
    .dest_x (i_data[2*COORD_W-1:COORD_W]),
    .dest_y (i_data[COORD_W-1:0]),
    .x_loc  (COORD_W'(X_LOC)),
    .y_loc  (COORD_W'(Y_LOC)),
    .route  (wr_route)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_ptr      <= '0;
      wr_ptr      <= '0;
      count       <= '0;
      o_overflow  <= 1'b0;
      o_underflow <= 1'b0;
    end else if (ce) begin
      if (wr) wr_ptr <= wr_ptr + AW'(1);
      if (rd) rd_ptr <= rd_ptr + AW'(1);
      count <= count + CW'(wr) - CW'(rd);
      if (i_valid & full)        o_overflow  <= 1'b1;
      if (i_input_grant & empty) o_underflow <= 1'b1;
    end
  end

  // Storage is never cleared; emptiness masks stale entries at the head.
  always_ff @(posedge clk) begin
    if (wr) begin
      data_mem[wr_ptr]  <= i_data;
      route_mem[wr_ptr] <= wr_route;
    end
  end

  assign o_en         = ~full;
  assign o_count      = count;
  assign o_output_req = empty ? '0 : route_mem[rd_ptr];
  assign o_data       = empty ? '0 : data_mem[rd_ptr];

endmodule

// File: tb/tb_input_unit.sv
// Scoreboard bench for input_unit at router (1,1): directed writes push the
// expected head {request, payload}; a monitor checks each granted pop.
module tb_input_unit;

  localparam int DEPTH = 4;
  localparam int DW    = 32;
  localparam int M     = 5;

  localparam logic [M-1:0] R_L = 5'b00001;
  localparam logic [M-1:0] R_N = 5'b00010;
  localparam logic [M-1:0] R_E = 5'b00100;
  localparam logic [M-1:0] R_S = 5'b01000;
  localparam logic [M-1:0] R_W = 5'b10000;

  typedef struct {
    logic [M-1:0]  req;
    logic [DW-1:0] data;
  } exp_t;

  logic          clk = 1'b0;
  logic          reset, ce, i_valid, i_input_grant;
  logic [DW-1:0] i_data;
  logic          o_en, o_overflow, o_underflow;
  logic [M-1:0]  o_output_req;
  logic [DW-1:0] o_data;
  logic [2:0]    o_count;

  int   total = 0;
  int   bad   = 0;
  exp_t sb[$];

  input_unit #(.DEPTH(DEPTH), .DATA_W(DW), .COORD_W(2), .M(M),
               .X_LOC(1), .Y_LOC(1)) dut (
    .clk           (clk),
    .reset         (reset),
    .ce            (ce),
    .i_data        (i_data),
    .i_valid       (i_valid),
    .o_en          (o_en),
    .o_output_req  (o_output_req),
    .i_input_grant (i_input_grant),
    .o_data        (o_data),
    .o_count       (o_count),
    .o_overflow    (o_overflow),
    .o_underflow   (o_underflow)
  );

  always #5 clk = ~clk;

  function automatic logic [DW-1:0] mk(input logic [1:0] x, input logic [1:0] y,
                                       input logic [27:0] p);
    return {p, x, y};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present a flit for one edge; push the expectation only if it should land.
  task automatic send(input logic [1:0] x, input logic [1:0] y, input logic [27:0] p,
                      input logic [M-1:0] r, input bit accept);
    exp_t e;
    i_data  = mk(x, y, p);
    i_valid = 1'b1;
    e.req   = r;
    e.data  = mk(x, y, p);
    if (accept) sb.push_back(e);
    step();
    i_valid = 1'b0;
  endtask

  // Monitor: every pop the DUT performs must match the next expected flit.
  always @(negedge clk) begin
    if (!reset && ce && i_input_grant && o_count != 0) begin
      total++;
      if (sb.size() == 0) begin
        bad++;
        $display("FAIL pop_unexpected: req=%b data=%0h with empty scoreboard", o_output_req, o_data);
      end else begin
        exp_t e;
        e = sb.pop_front();
        if (o_output_req !== e.req || o_data !== e.data) begin
          bad++;
          $display("FAIL pop: got req=%b data=%0h want req=%b data=%0h",
                   o_output_req, o_data, e.req, e.data);
        end
      end
    end
  end

  logic [1:0]   sx [10] = '{2'd2, 2'd0, 2'd1, 2'd1, 2'd1, 2'd3, 2'd0, 2'd1, 2'd2, 2'd0};
  logic [1:0]   sy [10] = '{2'd1, 2'd1, 2'd2, 2'd0, 2'd1, 2'd3, 2'd3, 2'd3, 2'd0, 2'd0};
  logic [M-1:0] sr [10] = '{R_E, R_W, R_N, R_S, R_L, R_E, R_W, R_N, R_E, R_W};

  initial begin
    reset = 1'b1; ce = 1'b1; i_valid = 1'b0; i_input_grant = 1'b0; i_data = '0;
    step(); step();
    reset = 1'b0;
    step();
    check("rst_en", 32'(o_en), 32'd1);
    check("rst_count", 32'(o_count), 32'd0);
    check("rst_req", 32'(o_output_req), 32'd0);
    check("rst_data", o_data, 32'd0);
    check("rst_ovf", 32'(o_overflow), 32'd0);
    check("rst_unf", 32'(o_underflow), 32'd0);

    // Fill to capacity; the fifth write hits a full queue and is dropped.
    send(2'd3, 2'd0, 28'h0000AA1, R_E, 1'b1);
    check("head_east_req", 32'(o_output_req), 32'(R_E));
    check("head_east_data", o_data, mk(2'd3, 2'd0, 28'h0000AA1));
    send(2'd0, 2'd2, 28'h0000AA2, R_W, 1'b1);
    send(2'd1, 2'd3, 28'h0000AA3, R_N, 1'b1);
    send(2'd1, 2'd0, 28'h0000AA4, R_S, 1'b1);
    check("full_en", 32'(o_en), 32'd0);
    send(2'd1, 2'd1, 28'h0000AA5, R_L, 1'b0);
    check("full_count", 32'(o_count), 32'd4);
    check("full_ovf", 32'(o_overflow), 32'd1);
    check("full_head_kept", 32'(o_output_req), 32'(R_E));

    // Drain with a held grant; monitor checks E, W, N, S in order.
    i_input_grant = 1'b1;
    step();
    check("en_after_pop", 32'(o_en), 32'd1);
    check("count_after_pop", 32'(o_count), 32'd3);
    step(); step(); step();
    i_input_grant = 1'b0;
    check("drained_count", 32'(o_count), 32'd0);
    check("drained_req", 32'(o_output_req), 32'd0);
    check("drained_data", o_data, 32'd0);
    check("drained_sb", 32'(sb.size()), 32'd0);

    // One-cycle latency: head visible the cycle after the write, popped next edge.
    send(2'd1, 2'd2, 28'h0000BB1, R_N, 1'b1);
    check("lat_req", 32'(o_output_req), 32'(R_N));
    check("lat_count", 32'(o_count), 32'd1);
    i_input_grant = 1'b1;
    step();
    i_input_grant = 1'b0;
    check("lat_popped", 32'(o_count), 32'd0);

    // Steady state at count=2: simultaneous write and pop for 10 cycles.
    send(2'd1, 2'd1, 28'h0000CC1, R_L, 1'b1);
    send(2'd3, 2'd2, 28'h0000CC2, R_E, 1'b1);
    check("ss_start", 32'(o_count), 32'd2);
    for (int k = 0; k < 10; k++) begin
      exp_t e;
      i_data        = mk(sx[k], sy[k], 28'h0000D00 + 28'(k));
      i_valid       = 1'b1;
      i_input_grant = 1'b1;
      e.req  = sr[k];
      e.data = i_data;
      sb.push_back(e);
      step();
      check($sformatf("ss_count_%0d", k), 32'(o_count), 32'd2);
    end
    i_valid = 1'b0;
    step(); step();
    i_input_grant = 1'b0;
    check("ss_drained", 32'(o_count), 32'd0);
    check("ss_sb", 32'(sb.size()), 32'd0);

    // Grant on an empty queue flags underflow, which is sticky.
    check("pre_unf", 32'(o_underflow), 32'd0);
    i_input_grant = 1'b1;
    step();
    i_input_grant = 1'b0;
    check("unf_set", 32'(o_underflow), 32'd1);
    check("unf_count", 32'(o_count), 32'd0);
    step(); step();
    check("unf_sticky", 32'(o_underflow), 32'd1);

    // Queue one flit, then freeze with ce=0: nothing moves.
    send(2'd2, 2'd2, 28'h0000EE1, R_E, 1'b0);
    ce = 1'b0;
    i_valid = 1'b1; i_input_grant = 1'b1;
    i_data = mk(2'd0, 2'd0, 28'h0000EE2);
    step(); step();
    check("ce0_count", 32'(o_count), 32'd1);
    check("ce0_req", 32'(o_output_req), 32'(R_E));
    check("ce0_ovf", 32'(o_overflow), 32'd1);

    // Reset wins over ce=0 and discards the queued flit.
    i_valid = 1'b0; i_input_grant = 1'b0;
    reset = 1'b1;
    step();
    check("rst2_count", 32'(o_count), 32'd0);
    check("rst2_req", 32'(o_output_req), 32'd0);
    check("rst2_data", o_data, 32'd0);
    check("rst2_ovf", 32'(o_overflow), 32'd0);
    check("rst2_unf", 32'(o_underflow), 32'd0);
    check("rst2_en", 32'(o_en), 32'd1);
    reset = 1'b0; ce = 1'b1;
    step();
    check("final_sb", 32'(sb.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
